// File: rtl/half_store_pkg.sv
// Shared types for the halfword store unit: FSM state encoding, size codes
// and the captured-request record.
package half_store_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic SIZE_HALF = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    typedef struct packed {
        logic [31:0] data;
        logic        size;
        logic        sign_op;
    } store_req_t;

endpackage

// File: rtl/half_store_narrow_check.sv
// Flags a 32-bit value that does not survive narrowing to 16 bits under
// signed (sign-extension) or unsigned (zero-extension) interpretation.
module narrow_check (
    input  logic [31:0] data,
    input  logic        sign_op,
    output logic        loss
);

    assign loss = sign_op ? (data[31:16] != {16{data[15]}})
                          : (data[31:16] != 16'h0000);

endmodule

// File: rtl/half_store_unit.sv
// Splits a halfword or word store into one or two writes on a 16-bit memory
// port. Define TRUNC_CHECK_EN to flag halfword stores that lose upper bits.
module half_store_unit
    import half_store_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              size,
    input  logic              sign_op,
    input  logic [31:0]       data_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              trunc_err
);

    state_t            state;
    store_req_t        req;
    logic [ADDR_W-1:0] addr_q;

    // Outputs are registered alongside the next state, so every write is
    // presented the cycle the FSM enters its state and holds until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req       <= '0;
            addr_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        req       <= '{data: data_in, size: size, sign_op: sign_op};
                        addr_q    <= addr_in;
                        state     <= WR_LO;
                        busy      <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_in;
                        mem_wdata <= data_in[15:0];
                    end
                end
                WR_LO: begin
                    if (mem_ready) begin
                        if (req.size == SIZE_WORD) begin
                            state     <= WR_HI;
                            mem_addr  <= addr_q + 1'b1;
                            mem_wdata <= req.data[31:16];
                        end else begin
                            state     <= DONE;
                            done      <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_wdata <= '0;
                        end
                    end
                end
                WR_HI: begin
                    if (mem_ready) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRUNC_CHECK_EN
    logic loss;

    narrow_check u_narrow_check (
        .data    (data_in),
        .sign_op (sign_op),
        .loss    (loss)
    );

    // Evaluated on the raw inputs at acceptance; held until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            trunc_err <= 1'b0;
        else if (state == IDLE && start)
            trunc_err <= (size == SIZE_HALF) && loss;
    end
`else
    assign trunc_err = 1'b0;
`endif

endmodule

// File: tb/tb_half_store_unit.sv
// Table-driven bench for half_store_unit with a write scoreboard and
// hand-written reset / busy-start sequences.
module tb_half_store_unit;

    typedef struct {
        logic        size;
        logic        sign_op;
        logic [31:0] data;
        logic [15:0] addr;
        int          stall;
        logic        exp_trunc;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        size = 1'b0;
    logic        sign_op = 1'b0;
    logic [31:0] data_in = '0;
    logic [15:0] addr_in = '0;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        trunc_err;

    int  n_chk = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    wr_t sb[$];
    wr_t mon_w;
    vec_t vecs[8];

    half_store_unit #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .size      (size),
        .sign_op   (sign_op),
        .data_in   (data_in),
        .addr_in   (addr_in),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .trunc_err (trunc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Writes are taken when mem_we and mem_ready meet at the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we && mem_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
                end else begin
                    mon_w = sb.pop_front();
                    chk("wr_addr", {16'h0, mem_addr}, {16'h0, mon_w.addr});
                    chk("wr_data", {16'h0, mem_wdata}, {16'h0, mon_w.data});
                end
            end else if (!mem_we) begin
                chk("idle_addr_zero", {16'h0, mem_addr}, 32'h0);
                chk("idle_data_zero", {16'h0, mem_wdata}, 32'h0);
            end
        end
    end

    function automatic logic trunc_model(input vec_t v);
`ifdef TRUNC_CHECK_EN
        return v.exp_trunc;
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_op(input vec_t v, input bit poke, input string name);
        int   t;
        int   we_cnt;
        bit   got;
        logic et;
        et = trunc_model(v);
        @(posedge clk); #1;
        start = 1'b1; size = v.size; sign_op = v.sign_op;
        data_in = v.data; addr_in = v.addr; mem_ready = 1'b0;
        sb.push_back('{v.addr, v.data[15:0]});
        if (v.size) sb.push_back('{v.addr + 16'd1, v.data[31:16]});
        @(posedge clk); #1;
        start = 1'b0;
        t = 1; we_cnt = 0; got = 1'b0;
        while (t < 40) begin
            mem_ready = (t > v.stall);
            if (poke && t == 1) begin
                start = 1'b1; data_in = ~v.data; addr_in = v.addr ^ 16'h00FF; size = ~v.size;
            end
            if (poke && t == 2) start = 1'b0;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (mem_we) begin
                we_cnt++;
                if (!mem_ready) begin
                    chk({name, ".stall_addr"}, {16'h0, mem_addr}, {16'h0, v.addr});
                    chk({name, ".stall_data"}, {16'h0, mem_wdata}, {16'h0, v.data[15:0]});
                end
            end
            @(posedge clk); #1;
            t++;
        end
        chk({name, ".done_seen"}, {31'h0, got}, 32'h1);
        if (got) begin
            chk({name, ".latency"}, t, (v.size ? 3 : 2) + v.stall);
            chk({name, ".we_cycles"}, we_cnt, (v.size ? 2 : 1) + v.stall);
            chk({name, ".busy_in_done"}, {31'h0, busy}, 32'h1);
            chk({name, ".we_in_done"}, {31'h0, mem_we}, 32'h0);
            chk({name, ".trunc_err"}, {31'h0, trunc_err}, {31'h0, et});
            if (poke) begin
                start = 1'b1; data_in = 32'hCAFEF00D; addr_in = 16'h0777; size = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk({name, ".done_pulse"}, {31'h0, done}, 32'h0);
            chk({name, ".busy_idle"}, {31'h0, busy}, 32'h0);
            chk({name, ".we_idle"}, {31'h0, mem_we}, 32'h0);
            chk({name, ".trunc_hold"}, {31'h0, trunc_err}, {31'h0, et});
        end
        chk({name, ".sb_empty"}, sb.size(), 0);
        sb.delete();
        mem_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h1234ABCD, 16'h0010, 0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'hFFFF8000, 16'h0100, 0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h00018000, 16'h0101, 0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 32'h00008000, 16'h0102, 0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF0001, 16'hFFFF, 0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h00005555, 16'h0042, 4, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'hDEAD0001, 16'h0300, 0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 32'h00000000, 16'h1234, 2, 1'b0};

        #12;
        chk("rst.mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst.mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst.mem_wdata", {16'h0, mem_wdata}, 32'h0);
        chk("rst.busy", {31'h0, busy}, 32'h0);
        chk("rst.done", {31'h0, done}, 32'h0);
        chk("rst.trunc_err", {31'h0, trunc_err}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Starts in WR_LO and in DONE must both be dropped.
        run_op('{1'b1, 1'b0, 32'h87654321, 16'h0500, 2, 1'b0}, 1'b1, "busy_start");

        // Reset while the upper half is being written.
        @(posedge clk); #1;
        start = 1'b1; size = 1'b1; sign_op = 1'b0; data_in = 32'hAAAA5555;
        addr_in = 16'h0200; mem_ready = 1'b1;
        sb.push_back('{16'h0200, 16'h5555});
        sb.push_back('{16'h0201, 16'hAAAA});
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("midrst.hi_we", {31'h0, mem_we}, 32'h1);
        chk("midrst.hi_addr", {16'h0, mem_addr}, 32'h0201);
        rst_n = 1'b0;
        #1;
        chk("midrst.we_now", {31'h0, mem_we}, 32'h0);
        chk("midrst.busy_now", {31'h0, busy}, 32'h0);
        chk("midrst.addr_now", {16'h0, mem_addr}, 32'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("midrst.no_done", {31'h0, done}, 32'h0);
            chk("midrst.no_busy", {31'h0, busy}, 32'h0);
        end
        chk("midrst.trunc_clr", {31'h0, trunc_err}, 32'h0);

        // Unit must be usable again after the aborted transfer.
        run_op('{1'b0, 1'b1, 32'h00007FFF, 16'h0600, 1, 1'b0}, 1'b0, "post_rst");

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
